virtual_interface_tx_scheduler: RTL and testbench
=================================================

// Module: virtual_interface_tx_scheduler
// PURPOSE
//  Owns the single UART byte transmitter of the button/LED virtual interface and shares it between three
//  frame requesters: button-frame acknowledge, LED-change report and periodic LED sync.
//  Sits between the user LED logic / UART receiver and the UART TX; sequences multi-byte frames byte by byte.
// PARAMETERS
//  CLKS_PER_SYNC   32'd1666666  period of the periodic LED sync request, in CLK cycles (>=2)
//  SEND_ON_CHANGE  0            1: LED value change raises a frame request; 0: change detection disabled
//  HDR_LEDS        8'h4C        first byte of an LED frame
//  HDR_ACK         8'h41        sole byte of an ACK frame
//  TX_TIMEOUT      32'd20000    max CLK cycles waited for tx_is_done per byte before abort (>=2)
// PORTS
//  CLK             in   1  system clock
//  RST_N           in   1  asynchronous, active-low reset
//  leds            in   8  current LED state to report
//  rx_is_done      in   1  1-cycle pulse: UART receiver completed a button frame
//  tx_in_progress  in   1  UART TX busy (status only, not used for sequencing)
//  tx_is_done      in   1  1-cycle pulse: UART TX finished the current byte
//  tx_start        out  1  1-cycle pulse: UART TX loads tx_byte
//  tx_byte         out  8  byte to transmit; stable from tx_start until tx_is_done/abort
//  busy            out  1  high while a frame is in flight (state != IDLE)
//  ack_overrun     out  1  1-cycle pulse: rx_is_done arrived while an ACK was already pending
//  tx_timeout      out  1  1-cycle pulse: byte not acknowledged within TX_TIMEOUT; frame aborted
// BEHAVIOUR
//  Reset (async, RST_N=0): all outputs 0, state IDLE, all pending flags 0, sync counter 0, last_sent 8'h00.
//  Pending flags (sticky, set has priority over clear in the same cycle):
//   ack_pend  set by rx_is_done; cleared when its ACK frame starts.
//   chg_pend  set when SEND_ON_CHANGE=1 and leds != last_sent; cleared when an LED frame starts.
//   sync_pend set when sync counter wraps; cleared when an LED frame starts.
//  Sync counter: free-running 0..CLKS_PER_SYNC-1, wraps to 0 and raises tick in the wrap cycle;
//   never reset by frame activity; ticks while sync_pend is set coalesce (no queueing).
//  Arbitration in IDLE, fixed priority: ACK > LED (chg_pend|sync_pend); one LED frame serves both flags.
//  Frames: ACK = {HDR_ACK} (1 byte); LED = {HDR_LEDS, snap} (2 bytes); snap/last_sent <= leds at frame start.
//  FSM:
//   IDLE  : any pending -> START, latch frame type, byte index 0, clear served flags.
//   START : tx_start=1 for exactly this cycle, tx_byte driven; -> WAIT, timeout counter 0.
//   WAIT  : tx_is_done -> last byte ? IDLE : START with index+1.
//           counter reaches TX_TIMEOUT-1 -> tx_timeout pulse, IDLE; remaining bytes dropped; flags not restored.
//  Latency: pending flag set in cycle N -> tx_start in N+2 when IDLE (N+1 flag visible, arbitration to START).
//  A new request arriving mid-frame waits for IDLE; no preemption, frames never interleave.
//  leds changing during an LED frame: snap unaffected; change re-detected against last_sent afterwards.
//  rx_is_done with ack_pend set and not cleared in that cycle -> ack_overrun pulse, single ACK kept.
//  tx_is_done in IDLE/START is ignored. tx_byte holds its last value in IDLE.
//  Reset mid-frame: frame lost, no partial resume; after release behaves as after power-up.
// STRUCTURE
//  Shared package/header: HDR_* defaults, FSM state encoding (IDLE/START/WAIT), frame-type encoding.
//  Sub-module: vi_sync_timer (CLKS_PER_SYNC counter, 1-cycle tick out, CLK/RST_N) - reusable by RX side.
//  Top holds pending flags, arbiter, FSM, byte mux, timeout counter.
// TESTING (bench overrides CLKS_PER_SYNC=100, TX_TIMEOUT=50; TX model pulses tx_is_done 10 clks after tx_start)
//  1 Reset, SEND_ON_CHANGE=0, leds=8'hA5 -> first tx_start at counter wrap: bytes 8'h4C,8'hA5, then idle 100 clks.
//  2 rx_is_done pulse and sync tick same cycle -> ACK 8'h41 sent first, then 8'h4C,8'hA5; no ack_overrun.
//  3 SEND_ON_CHANGE=1, leds 8'h00->8'h3C -> tx_start 2 clks later, bytes 8'h4C,8'h3C; no frame while leds stable.
//  4 Two rx_is_done pulses 3 clks apart during an LED frame -> one ack_overrun pulse, exactly one ACK after frame.
//  5 TX model withholds tx_is_done -> tx_timeout pulse 50 clks after tx_start, busy=0 next cycle, next request served.
//  6 RST_N low during WAIT of byte 2 -> outputs 0 immediately; after release no byte 8'hxx resumed, last_sent=0.

Source files
------------

// File: rtl/virtual_interface_tx_scheduler_pkg.sv
// virtual_interface_tx_scheduler_pkg: shared frame headers, FSM state and frame-type encodings
package virtual_interface_tx_scheduler_pkg;
  localparam logic [7:0] HDR_LEDS_DEF = 8'h4C;
  localparam logic [7:0] HDR_ACK_DEF  = 8'h41;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  typedef enum logic {FT_ACK = 1'b0, FT_LED = 1'b1} frame_t;
endpackage

// File: rtl/virtual_interface_tx_scheduler_sync_timer.sv
// vi_sync_timer: free-running period counter with a one-cycle tick in its wrap cycle
module vi_sync_timer #(
  parameter logic [31:0] CLKS_PER_SYNC = 32'd1666666
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  logic [31:0] cnt;
  assign tick = cnt == CLKS_PER_SYNC - 32'd1;
  // count 0..CLKS_PER_SYNC-1, wrapping to 0 on the tick
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 32'd1;
endmodule

// File: rtl/virtual_interface_tx_scheduler.sv
// virtual_interface_tx_scheduler: shares one UART byte transmitter between ACK, LED-change and LED-sync frames
module virtual_interface_tx_scheduler
  import virtual_interface_tx_scheduler_pkg::*;
#(
  parameter logic [31:0] CLKS_PER_SYNC  = 32'd1666666,
  parameter logic        SEND_ON_CHANGE = 1'b0,
  parameter logic [7:0]  HDR_LEDS       = HDR_LEDS_DEF,
  parameter logic [7:0]  HDR_ACK        = HDR_ACK_DEF,
  parameter logic [31:0] TX_TIMEOUT     = 32'd20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] leds,
  input  logic       rx_is_done,
  input  logic       tx_in_progress,
  input  logic       tx_is_done,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  output logic       busy,
  output logic       ack_overrun,
  output logic       tx_timeout
);
  logic [1:0] state;
  frame_t ft;
  logic idx;
  logic [7:0] snap, last_sent;
  logic [31:0] tcnt;
  logic ack_pend, chg_pend, sync_pend, tick;
  logic go_ack, go_led, chg_set, last_byte, unused_ok;
  vi_sync_timer #(.CLKS_PER_SYNC(CLKS_PER_SYNC)) u_sync (.clk(clk), .rst_n(rst_n), .tick(tick));
  assign unused_ok = tx_in_progress;
  assign tx_start = state == S_START;
  assign busy = state != S_IDLE;
  assign tx_timeout = state == S_WAIT && !tx_is_done && tcnt == TX_TIMEOUT - 32'd1;
  assign ack_overrun = rx_is_done && ack_pend && !go_ack;
  // fixed-priority arbitration; the frame-start cycle does not re-detect the change it is about to send
  always_comb begin
    go_ack = state == S_IDLE && ack_pend;
    go_led = state == S_IDLE && !ack_pend && (chg_pend || sync_pend);
    chg_set = SEND_ON_CHANGE && leds != last_sent && !go_led;
    last_byte = ft == FT_ACK || idx;
  end
  // sticky request flags, a new request wins over the clear of a starting frame
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ack_pend <= 1'b0;
      chg_pend <= 1'b0;
      sync_pend <= 1'b0;
    end else begin
      ack_pend <= rx_is_done || (ack_pend && !go_ack);
      chg_pend <= chg_set || (chg_pend && !go_led);
      sync_pend <= tick || (sync_pend && !go_led);
    end
  // frame sequencer: IDLE picks a frame, START pulses the TX, WAIT holds until done or timeout
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      ft <= FT_ACK;
      idx <= 1'b0;
      tx_byte <= 8'h00;
      snap <= 8'h00;
      last_sent <= 8'h00;
      tcnt <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (go_ack || go_led) begin
            state <= S_START;
            ft <= go_ack ? FT_ACK : FT_LED;
            idx <= 1'b0;
            tx_byte <= go_ack ? HDR_ACK : HDR_LEDS;
            if (go_led) begin
              snap <= leds;
              last_sent <= leds;
            end
          end
        S_START: begin
          state <= S_WAIT;
          tcnt <= '0;
        end
        S_WAIT:
          if (tx_is_done) begin
            state <= last_byte ? S_IDLE : S_START;
            if (!last_byte) begin
              idx <= 1'b1;
              tx_byte <= snap;
            end
          end else if (tcnt == TX_TIMEOUT - 32'd1) state <= S_IDLE;
          else tcnt <= tcnt + 32'd1;
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_virtual_interface_tx_scheduler.sv
// tb_virtual_interface_tx_scheduler: scoreboard and vector-table bench for the TX scheduler
module tb_virtual_interface_tx_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] leds0, leds1;
  logic rx0, rx1, hold0;
  logic tx_done0, tx_done1;
  logic [3:0] d0, d1;
  logic tx_start0, busy0, ack_overrun0, tx_timeout0;
  logic tx_start1, busy1, ack_overrun1, tx_timeout1;
  logic [7:0] tx_byte0, tx_byte1;
  int total = 0, bad = 0, ovr0 = 0, ovr1 = 0, cyc = 0;
  logic mon0 = 1'b1;
  logic [7:0] q0[$], q1[$];

  typedef struct {
    logic [7:0] leds;
    logic       rx;
    int         n;
    logic [7:0] b0, b1, b2;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  // u0: periodic sync only; u1: change detection with a sync period far beyond the run length
  virtual_interface_tx_scheduler #(.CLKS_PER_SYNC(32'd100), .SEND_ON_CHANGE(1'b0), .TX_TIMEOUT(32'd50)) u0 (
    .clk(clk), .rst_n(rst_n), .leds(leds0), .rx_is_done(rx0), .tx_in_progress(d0 != 4'd0),
    .tx_is_done(tx_done0), .tx_start(tx_start0), .tx_byte(tx_byte0), .busy(busy0),
    .ack_overrun(ack_overrun0), .tx_timeout(tx_timeout0));
  virtual_interface_tx_scheduler #(.CLKS_PER_SYNC(32'd60000), .SEND_ON_CHANGE(1'b1), .TX_TIMEOUT(32'd50)) u1 (
    .clk(clk), .rst_n(rst_n), .leds(leds1), .rx_is_done(rx1), .tx_in_progress(d1 != 4'd0),
    .tx_is_done(tx_done1), .tx_start(tx_start1), .tx_byte(tx_byte1), .busy(busy1),
    .ack_overrun(ack_overrun1), .tx_timeout(tx_timeout1));

  // cycle index since the last reset release
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  // UART TX models: tx_is_done 10 clks after tx_start (u0 can withhold it)
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      d0 <= 4'd0;
      tx_done0 <= 1'b0;
    end else begin
      tx_done0 <= 1'b0;
      if (tx_start0) d0 <= 4'd1;
      else if (d0 == 4'd9) begin
        d0 <= 4'd0;
        tx_done0 <= !hold0;
      end else if (d0 != 4'd0) d0 <= d0 + 4'd1;
    end
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      d1 <= 4'd0;
      tx_done1 <= 1'b0;
    end else begin
      tx_done1 <= 1'b0;
      if (tx_start1) d1 <= 4'd1;
      else if (d1 == 4'd9) begin
        d1 <= 4'd0;
        tx_done1 <= 1'b1;
      end else if (d1 != 4'd0) d1 <= d1 + 4'd1;
    end

  // scoreboard: every tx_start pops the next expected byte
  always @(negedge clk) begin
    logic [7:0] e;
    #2;
    if (rst_n) begin
      if (ack_overrun0) ovr0++;
      if (ack_overrun1) ovr1++;
      if (tx_start0 && mon0) begin
        total++;
        if (q0.size() == 0) begin
          bad++;
          $display("FAIL u0_byte: got %h while nothing expected", tx_byte0);
        end else begin
          e = q0.pop_front();
          if (tx_byte0 !== e) begin
            bad++;
            $display("FAIL u0_byte: got %h expected %h", tx_byte0, e);
          end
        end
      end
      if (tx_start1) begin
        total++;
        if (q1.size() == 0) begin
          bad++;
          $display("FAIL u1_byte: got %h while nothing expected", tx_byte1);
        end else begin
          e = q1.pop_front();
          if (tx_byte1 !== e) begin
            bad++;
            $display("FAIL u1_byte: got %h expected %h", tx_byte1, e);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic to_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'h5A, 1'b0, 2, 8'h4C, 8'h5A, 8'h00};
    tbl[1] = '{8'h5A, 1'b1, 1, 8'h41, 8'h00, 8'h00};
    tbl[2] = '{8'hFF, 1'b1, 3, 8'h41, 8'h4C, 8'hFF};
    tbl[3] = '{8'h00, 1'b0, 2, 8'h4C, 8'h00, 8'h00};
    tbl[4] = '{8'h00, 1'b0, 0, 8'h00, 8'h00, 8'h00};
    tbl[5] = '{8'h81, 1'b1, 3, 8'h41, 8'h4C, 8'h81};
    leds0 = 8'hA5;
    leds1 = 8'h00;
    rx0 = 1'b0;
    rx1 = 1'b0;
    hold0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tx_start", tx_start0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_tx_byte", tx_byte0, 0);
    chk("rst_overrun", ack_overrun0, 0);
    chk("rst_timeout", tx_timeout0, 0);
    chk("rst_busy1", busy1, 0);
    rst_n = 1'b1;
    // 1: first LED sync frame at the counter wrap
    q0.push_back(8'h4C); q0.push_back(8'hA5);
    to_cycle(100); chk("t1_early", tx_start0, 0);
    to_cycle(101); chk("t1_start", tx_start0, 1); chk("t1_hdr", tx_byte0, 8'h4C);
    to_cycle(150); chk("t1_idle", busy0, 0); chk("t1_drained", q0.size(), 0);
    // 2: ACK request and sync tick in the same cycle, ACK wins
    q0.push_back(8'h41); q0.push_back(8'h4C); q0.push_back(8'hA5);
    to_cycle(199); rx0 = 1'b1; @(negedge clk); rx0 = 1'b0;
    to_cycle(201); chk("t2_ack_start", tx_start0, 1); chk("t2_ack_byte", tx_byte0, 8'h41);
    to_cycle(240); chk("t2_drained", q0.size(), 0); chk("t2_no_overrun", ovr0, 0);
    // 4: two ACK requests during an LED frame collapse into one ACK
    q0.push_back(8'h4C); q0.push_back(8'hA5); q0.push_back(8'h41);
    to_cycle(305); rx0 = 1'b1; @(negedge clk); rx0 = 1'b0;
    to_cycle(308); rx0 = 1'b1; @(negedge clk); rx0 = 1'b0;
    to_cycle(324); chk("t4_ack_start", tx_start0, 1); chk("t4_ack_byte", tx_byte0, 8'h41);
    to_cycle(345); chk("t4_overrun", ovr0, 1); chk("t4_drained", q0.size(), 0);
    // 5: withheld tx_is_done aborts the frame after the timeout
    hold0 = 1'b1;
    q0.push_back(8'h4C); q0.push_back(8'h41);
    to_cycle(401); chk("t5_start", tx_start0, 1);
    to_cycle(450); chk("t5_no_timeout", tx_timeout0, 0);
    to_cycle(451); chk("t5_timeout", tx_timeout0, 1); chk("t5_busy", busy0, 1);
    to_cycle(452); chk("t5_idle", busy0, 0); chk("t5_pulse_end", tx_timeout0, 0);
    hold0 = 1'b0;
    to_cycle(455); rx0 = 1'b1; @(negedge clk); rx0 = 1'b0;
    to_cycle(457); chk("t5_next_start", tx_start0, 1); chk("t5_next_byte", tx_byte0, 8'h41);
    to_cycle(480); chk("t5_drained", q0.size(), 0);
    // 6: reset during the wait for byte 2
    q0.push_back(8'h4C); q0.push_back(8'hA5);
    to_cycle(515); chk("t6_busy_pre", busy0, 1); chk("t6_byte_pre", tx_byte0, 8'hA5);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_start", tx_start0, 0); chk("t6_rst_busy", busy0, 0);
    chk("t6_rst_byte", tx_byte0, 0); chk("t6_rst_timeout", tx_timeout0, 0);
    chk("t6_seen", q0.size(), 0);
    leds1 = 8'h3C;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    q0.push_back(8'h4C); q0.push_back(8'hA5);
    q1.push_back(8'h4C); q1.push_back(8'h3C);
    to_cycle(2); chk("t6_last_sent_clr", tx_start1, 1); chk("t6_u1_hdr", tx_byte1, 8'h4C);
    to_cycle(100); chk("t6_no_resume", busy0, 0);
    to_cycle(101); chk("t6_fresh_start", tx_start0, 1);
    to_cycle(130); chk("t6_drained0", q0.size(), 0); chk("t6_drained1", q1.size(), 0);
    mon0 = 1'b0;
    // 3: change detection latency and silence while leds stay stable
    q1.push_back(8'h4C); q1.push_back(8'h00);
    to_cycle(140); leds1 = 8'h00;
    to_cycle(200); leds1 = 8'h3C;
    q1.push_back(8'h4C); q1.push_back(8'h3C);
    to_cycle(201); chk("t3_early", tx_start1, 0);
    to_cycle(202); chk("t3_start", tx_start1, 1); chk("t3_hdr", tx_byte1, 8'h4C);
    to_cycle(230); chk("t3_idle_a", busy1, 0);
    to_cycle(300); chk("t3_idle_b", busy1, 0);
    to_cycle(380); chk("t3_idle_c", busy1, 0); chk("t3_drained", q1.size(), 0);
    // vector table: leds/rx stimulus per slot with expected byte sequence
    for (int i = 0; i < 6; i++) begin
      to_cycle(400 + 60 * i);
      leds1 = tbl[i].leds;
      rx1 = tbl[i].rx;
      if (tbl[i].n > 0) q1.push_back(tbl[i].b0);
      if (tbl[i].n > 1) q1.push_back(tbl[i].b1);
      if (tbl[i].n > 2) q1.push_back(tbl[i].b2);
      @(negedge clk);
      rx1 = 1'b0;
      to_cycle(455 + 60 * i);
      chk($sformatf("vec%0d_idle", i), busy1, 0);
      chk($sformatf("vec%0d_drained", i), q1.size(), 0);
    end
    chk("u1_no_overrun", ovr1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
